cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 133 +++++++++++++
 tb/tb_cdb_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Arbitrates NUM_SRC functional-unit results onto NUM_BUS common data buses.
//   Grants are combinational (src_ready); the winning results are broadcast
//   on the buses one cycle later from registers.
//
// Ports
//   clock       : single clock, all state changes on the rising edge
//   reset_n     : synchronous active-low reset
//   flush       : squash; no grants, broadcasts cleared, pointer and count held
//   src_valid   : per-source result request
//   src_robNum  : packed ROB indices, source i at [i*ROB_W +: ROB_W]
//   src_data    : packed results, source i at [i*DATA_W +: DATA_W]
//   src_ready   : per-source grant, high in the cycle the result is taken
//   iscast_out  : registered per-bus broadcast valid
//   robNum_out  : registered per-bus ROB index, packed
//   data_out    : registered per-bus data, packed
//   drop_count  : saturating count of valid requests left ungranted
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_SRC  = 4,
  parameter int NUM_BUS  = 2,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]  src_robNum,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [NUM_BUS-1:0]        iscast_out,
  output logic [NUM_BUS*ROB_W-1:0]  robNum_out,
  output logic [NUM_BUS*DATA_W-1:0] data_out,
  output logic [15:0]               drop_count
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [PTR_W-1:0]          r_ptr;
  logic [NUM_BUS-1:0]        r_cast;
  logic [NUM_BUS*ROB_W-1:0]  r_rob;
  logic [NUM_BUS*DATA_W-1:0] r_data;
  logic [15:0]               r_drop;

  logic                      w_active;
  logic [NUM_SRC-1:0]        w_grant;
  logic [NUM_BUS-1:0]        w_cast;
  logic [NUM_BUS*ROB_W-1:0]  w_bus_rob;
  logic [NUM_BUS*DATA_W-1:0] w_bus_data;
  logic [PTR_W-1:0]          w_ptr_nxt;
  logic [16:0]               w_drop_sum;
  int                        w_start;
  int                        w_n_gnt;
  int                        w_drop_inc;

  // Reset and flush both suppress every grant in the current cycle.
  assign w_active = reset_n & ~flush;

  // Scan order is start, start+1, ... modulo NUM_SRC. The rotation is unrolled
  // for every possible start value so all source/bus indices are constants and
  // the wrap-around costs no extra cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    w_grant    = '0;
    w_cast     = '0;
    w_bus_rob  = '0;
    w_bus_data = '0;
    w_ptr_nxt  = r_ptr;
    w_n_gnt    = 0;
    w_drop_inc = 0;
    w_start    = (ARB_MODE == 0) ? int'(r_ptr) : 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (s == w_start) begin
        for (int j = 0; j < NUM_SRC; j++) begin
          if (w_active && src_valid[(s + j) % NUM_SRC]) begin
            if (w_n_gnt < NUM_BUS) begin
              w_grant[(s + j) % NUM_SRC] = 1'b1;
              // The k-th winner in scan order owns bus k.
              for (int k = 0; k < NUM_BUS; k++) begin
                if (k == w_n_gnt) begin
                  w_cast[k]                       = 1'b1;
                  w_bus_rob[k*ROB_W +: ROB_W]     = src_robNum[((s + j) % NUM_SRC)*ROB_W +: ROB_W];
                  w_bus_data[k*DATA_W +: DATA_W]  = src_data[((s + j) % NUM_SRC)*DATA_W +: DATA_W];
                end
              end
              if (ARB_MODE == 0) begin
                w_ptr_nxt = PTR_W'((s + j + 1) % NUM_SRC);
              end
              w_n_gnt = w_n_gnt + 1;
            end else begin
              w_drop_inc = w_drop_inc + 1;
            end
          end
        end
      end
    end
  end

  // One bit of headroom detects overflow of the 16-bit drop counter.
  assign w_drop_sum = {1'b0, r_drop} + 17'(w_drop_inc);

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (!reset_n) begin
      r_ptr  <= '0;
      r_cast <= '0;
      r_rob  <= '0;
      r_data <= '0;
      r_drop <= '0;
    end else if (flush) begin
      // Bus payload is left as-is; it is meaningless while iscast_out is 0.
      r_cast <= '0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_cast <= w_cast;
      r_rob  <= w_bus_rob;
      r_data <= w_bus_data;
      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign src_ready  = w_grant;
  assign iscast_out = r_cast;
  assign robNum_out = r_rob;
  assign data_out   = r_data;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter. A round-robin instance (4 sources, 2 buses)
//   is driven from a vector table plus hand sequences for reset and drop-count
//   saturation; a fixed-priority instance (4 sources, 1 bus) checks that the
//   lowest index always wins.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam logic [31:0]  D0 = 32'hA0A0_0000;
  localparam logic [31:0]  D1 = 32'hA1A1_0001;
  localparam logic [31:0]  D2 = 32'hA2A2_0002;
  localparam logic [31:0]  D3 = 32'hA3A3_0003;
  localparam logic [127:0] DALL = {D3, D2, D1, D0};
  localparam logic [15:0]  RALL = 16'hBA98; // src0=8, src1=9, src2=A, src3=B

  logic         clock = 1'b0;
  logic         reset_n;
  logic         flush;
  logic [3:0]   src_valid;
  logic [15:0]  src_robNum;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic [1:0]   iscast_out;
  logic [7:0]   robNum_out;
  logic [63:0]  data_out;
  logic [15:0]  drop_count;

  logic         flush2;
  logic [3:0]   valid2;
  logic [15:0]  rob2;
  logic [127:0] data2;
  logic [3:0]   ready2;
  logic [0:0]   cast2;
  logic [3:0]   robout2;
  logic [31:0]  dataout2;
  logic [15:0]  drop2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(.NUM_SRC(4), .NUM_BUS(2), .DATA_W(32), .ROB_W(4), .ARB_MODE(0)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .src_valid(src_valid),
    .src_robNum(src_robNum), .src_data(src_data), .src_ready(src_ready),
    .iscast_out(iscast_out), .robNum_out(robNum_out), .data_out(data_out),
    .drop_count(drop_count)
  );

  cdb_arbiter #(.NUM_SRC(4), .NUM_BUS(1), .DATA_W(32), .ROB_W(4), .ARB_MODE(1)) dut_fp (
    .clock(clock), .reset_n(reset_n), .flush(flush2), .src_valid(valid2),
    .src_robNum(rob2), .src_data(data2), .src_ready(ready2),
    .iscast_out(cast2), .robNum_out(robout2), .data_out(dataout2),
    .drop_count(drop2)
  );

  typedef struct {
    logic         flush;
    logic [3:0]   valid;
    logic [15:0]  rob;
    logic [127:0] data;
    logic [3:0]   ready;  // expected grants in the same cycle
    logic [1:0]   cast;   // expected iscast_out after the edge
    logic [7:0]   brob;   // expected robNum_out (only live buses compared)
    logic [63:0]  bdata;  // expected data_out (only live buses compared)
    logic [15:0]  drop;   // expected drop_count after the edge
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int n);
    flush      = v.flush;
    src_valid  = v.valid;
    src_robNum = v.rob;
    src_data   = v.data;
    #1;
    check($sformatf("v%0d src_ready", n), 128'(src_ready), 128'(v.ready));
    @(posedge clock);
    #1;
    check($sformatf("v%0d iscast", n), 128'(iscast_out), 128'(v.cast));
    for (int k = 0; k < 2; k++) begin
      if (v.cast[k]) begin
        check($sformatf("v%0d bus%0d rob", n, k), 128'(robNum_out[k*4 +: 4]), 128'(v.brob[k*4 +: 4]));
        check($sformatf("v%0d bus%0d data", n, k), 128'(data_out[k*32 +: 32]), 128'(v.bdata[k*32 +: 32]));
      end
    end
    check($sformatf("v%0d drop_count", n), 128'(drop_count), 128'(v.drop));
  endtask

  initial begin
    // Sequence state noted as (ptr, drop) after each row.
    vecs[0]  = '{1'b0, 4'b1111, RALL, DALL, 4'b0011, 2'b11, 8'h98, {D1, D0}, 16'd2}; // (2,2)
    vecs[1]  = '{1'b0, 4'b1111, RALL, DALL, 4'b1100, 2'b11, 8'hBA, {D3, D2}, 16'd4}; // (0,4)
    vecs[2]  = '{1'b0, 4'b0100, 16'hB598, {D3, 32'hDEAD_BEEF, D1, D0},
                 4'b0100, 2'b01, 8'h05, {32'h0, 32'hDEAD_BEEF}, 16'd4};               // (3,4)
    vecs[3]  = '{1'b0, 4'b0000, RALL, DALL, 4'b0000, 2'b00, 8'h00, 64'h0, 16'd4};     // (3,4)
    vecs[4]  = '{1'b0, 4'b1001, RALL, DALL, 4'b1001, 2'b11, 8'h8B, {D0, D3}, 16'd4}; // (1,4)
    vecs[5]  = '{1'b0, 4'b1111, RALL, DALL, 4'b0110, 2'b11, 8'hA9, {D2, D1}, 16'd6}; // (3,6)
    vecs[6]  = '{1'b1, 4'b0110, RALL, DALL, 4'b0000, 2'b00, 8'h00, 64'h0, 16'd6};     // (3,6)
    vecs[7]  = '{1'b0, 4'b0110, RALL, DALL, 4'b0110, 2'b11, 8'hA9, {D2, D1}, 16'd6}; // (3,6)
    vecs[8]  = '{1'b0, 4'b1110, RALL, DALL, 4'b1010, 2'b11, 8'h9B, {D1, D3}, 16'd7}; // (2,7)
    vecs[9]  = '{1'b0, 4'b0001, RALL, DALL, 4'b0001, 2'b01, 8'h08, {32'h0, D0}, 16'd7}; // (1,7)
    vecs[10] = '{1'b0, 4'b1101, RALL, DALL, 4'b1100, 2'b11, 8'hBA, {D3, D2}, 16'd8}; // (0,8)

    reset_n = 1'b0; flush = 1'b0; src_valid = '0; src_robNum = RALL; src_data = DALL;
    flush2 = 1'b0; valid2 = '0; rob2 = RALL; data2 = DALL;
    repeat (2) @(posedge clock);
    #1;
    check("reset iscast", 128'(iscast_out), 128'(0));
    check("reset rob", 128'(robNum_out), 128'(0));
    check("reset data", 128'(data_out), 128'(0));
    check("reset drop", 128'(drop_count), 128'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) apply(vecs[i], i);

    // Reset in the middle of all-valid traffic: grants vanish immediately,
    // the next edge clears everything, and the pointer restarts at 0.
    apply('{1'b0, 4'b1111, RALL, DALL, 4'b0011, 2'b11, 8'h98, {D1, D0}, 16'd10}, 11);
    reset_n = 1'b0;
    #1;
    check("rst src_ready", 128'(src_ready), 128'(0));
    @(posedge clock);
    #1;
    check("rst iscast", 128'(iscast_out), 128'(0));
    check("rst rob", 128'(robNum_out), 128'(0));
    check("rst data", 128'(data_out), 128'(0));
    check("rst drop", 128'(drop_count), 128'(0));
    reset_n = 1'b1;
    apply('{1'b0, 4'b1111, RALL, DALL, 4'b0011, 2'b11, 8'h98, {D1, D0}, 16'd2}, 12);

    // Fixed priority, one bus: source 0 must win every cycle over source 3.
    src_valid = '0;
    valid2 = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("fp%0d ready", i), 128'(ready2), 128'(4'b0001));
      @(posedge clock);
      #1;
      check($sformatf("fp%0d iscast", i), 128'(cast2), 128'(1'b1));
      check($sformatf("fp%0d rob", i), 128'(robout2), 128'(4'h8));
      check($sformatf("fp%0d data", i), 128'(dataout2), 128'(D0));
    end
    check("fp drop_count", 128'(drop2), 128'(16'd5));
    valid2 = '0;
    check("main drop held while idle", 128'(drop_count), 128'(16'd2));

    // Saturation: two drops per cycle from 2 reaches 0xFFFF well before the end.
    src_valid = 4'b1111;
    repeat (32800) @(posedge clock);
    #1;
    check("drop saturated", 128'(drop_count), 128'(16'hFFFF));
    flush = 1'b1;
    #1;
    check("flush src_ready", 128'(src_ready), 128'(0));
    @(posedge clock);
    #1;
    check("flush iscast", 128'(iscast_out), 128'(0));
    check("drop after flush", 128'(drop_count), 128'(16'hFFFF));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
